// File: rtl/pe_vec_mac.sv
// pe_vec_mac: systolic-array processing element computing a LANES-wide dot
// product of activation and weight vectors per beat, with a valid/ready
// handshake.
//
// Modes (sampled per beat):
//   0 = chain:      out_psum = fix(in_psum + dot)
//   1 = accumulate: acc gathers dot products over a group.
//                   first seeds acc from in_psum; last emits the result.
//
// Ports:
//   clk, rst         rising-edge clock; asynchronous active-high reset
//   in_valid/ready   input beat handshake (in_ready = !stall)
//   activation       LANES packed elements, lane i at [i*weightPar +: weightPar]
//   weight           same packing as activation
//   in_psum          incoming two's-complement partial sum
//   mode/first/last  per-beat control, see above
//   out_valid/ready  result handshake
//   out_psum         two's-complement result
//   overflow         sideband, qualified by out_valid
module pe_vec_mac #(
  parameter int weightPar       = 8,
  parameter int accumulationPar = 32,
  parameter int LANES           = 4,
  parameter int SeM             = 0,
  parameter int SATURATE        = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*weightPar-1:0]   activation,
  input  logic [LANES*weightPar-1:0]   weight,
  input  logic [accumulationPar-1:0]   in_psum,
  input  logic                         mode,
  input  logic                         first,
  input  logic                         last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [accumulationPar-1:0]   out_psum,
  output logic                         overflow
);

  localparam int W = weightPar;
  localparam int A = accumulationPar;
  // One guard bit above the result width makes every sum exact before fix().
  localparam int X = accumulationPar + 1;

  generate
    if (A < 2 * W + $clog2(LANES)) begin : gParamCheck
      $error("pe_vec_mac: accumulationPar too small for weightPar/LANES");
    end
  endgenerate

  // Product of one lane, sign-extended to X bits.
  function automatic logic signed [X-1:0] laneProduct(input logic [W-1:0] a,
                                                       input logic [W-1:0] w);
    logic [2*W-1:0]        magA;
    logic [2*W-1:0]        magW;
    logic [2*W-1:0]        mag;
    logic signed [2*W-1:0] prod;
    magA = {{(W+1){1'b0}}, a[W-2:0]};
    magW = {{(W+1){1'b0}}, w[W-2:0]};
    mag  = magA * magW;
    if (SeM != 0) begin
      // Negating a zero magnitude gives zero, so -0 operands yield exactly 0.
      if ((a[W-1] ^ w[W-1]) == 1'b1) begin
        prod = -$signed(mag);
      end else begin
        prod = $signed(mag);
      end
    end else begin
      prod = $signed(a) * $signed(w);
    end
    return X'(prod);
  endfunction

  // True when x does not fit in A signed bits.
  function automatic logic isOvf(input logic signed [X-1:0] x);
    return x[X-1] ^ x[X-2];
  endfunction

  // Reduce an X-bit value to A bits by clamping or wrapping.
  function automatic logic [A-1:0] fixVal(input logic signed [X-1:0] x);
    logic [A-1:0] res;
    if (isOvf(x) && (SATURATE != 0)) begin
      if (x[X-1] == 1'b1) begin
        res = {1'b1, {(A-1){1'b0}}};
      end else begin
        res = {1'b0, {(A-1){1'b1}}};
      end
    end else begin
      res = x[A-1:0];
    end
    return res;
  endfunction

  logic                       s1Valid_r;
  logic [LANES*W-1:0]         s1Act_r;
  logic [LANES*W-1:0]         s1Wgt_r;
  logic [A-1:0]               s1Psum_r;
  logic                       s1Mode_r;
  logic                       s1First_r;
  logic                       s1Last_r;

  logic                       outValid_r;
  logic [A-1:0]               outPsum_r;
  logic                       overflow_r;
  logic [A-1:0]               acc_r;
  logic                       sticky_r;

  logic                       stall_s;
  logic                       accept_s;
  logic signed [X-1:0]        dot_s;
  logic signed [X-1:0]        base_s;
  logic signed [X-1:0]        sum_s;
  logic [A-1:0]               sumFix_s;
  logic                       sumOvf_s;
  logic                       stickyNext_s;

  assign stall_s   = outValid_r & ~out_ready;
  assign in_ready  = ~stall_s;
  assign accept_s  = in_valid & ~stall_s;
  assign out_valid = outValid_r;
  assign out_psum  = outPsum_r;
  assign overflow  = overflow_r;

  // Stage-2 arithmetic: dot product, base selection, fix and sticky update.
  always_comb begin
    dot_s = '0;
    for (int i = 0; i < LANES; i++) begin
      dot_s = dot_s + laneProduct(s1Act_r[i*W +: W], s1Wgt_r[i*W +: W]);
    end
    // Chain beats and group-opening beats start from in_psum; others from acc.
    if (s1Mode_r && !s1First_r) begin
      base_s = X'($signed(acc_r));
    end else begin
      base_s = X'($signed(s1Psum_r));
    end
    sum_s        = base_s + dot_s;
    sumFix_s     = fixVal(sum_s);
    sumOvf_s     = isOvf(sum_s);
    stickyNext_s = (s1First_r ? 1'b0 : sticky_r) | sumOvf_s;
  end

  // Stage-1 operand register; holds its beat while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_r <= 1'b0;
      s1Act_r   <= '0;
      s1Wgt_r   <= '0;
      s1Psum_r  <= '0;
      s1Mode_r  <= 1'b0;
      s1First_r <= 1'b0;
      s1Last_r  <= 1'b0;
    end else if (!stall_s) begin
      s1Valid_r <= accept_s;
      if (accept_s) begin
        s1Act_r   <= activation;
        s1Wgt_r   <= weight;
        s1Psum_r  <= in_psum;
        s1Mode_r  <= mode;
        s1First_r <= first;
        s1Last_r  <= last;
      end
    end
  end

  // Stage-2 result register plus accumulator and sticky overflow state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_r <= 1'b0;
      outPsum_r  <= '0;
      overflow_r <= 1'b0;
      acc_r      <= '0;
      sticky_r   <= 1'b0;
    end else if (!stall_s) begin
      if (s1Valid_r) begin
        if (!s1Mode_r) begin
          // Chain beat: acc and sticky flag stay untouched.
          outValid_r <= 1'b1;
          outPsum_r  <= sumFix_s;
          overflow_r <= sumOvf_s;
        end else if (s1Last_r) begin
          outValid_r <= 1'b1;
          outPsum_r  <= sumFix_s;
          overflow_r <= stickyNext_s;
          acc_r      <= '0;
          sticky_r   <= 1'b0;
        end else begin
          outValid_r <= 1'b0;
          acc_r      <= sumFix_s;
          sticky_r   <= stickyNext_s;
        end
      end else begin
        outValid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_vec_mac.sv
// Directed testbench for pe_vec_mac. Four instances share one stimulus:
// default (two's complement, 32-bit, saturating), sign-magnitude, and two
// single-lane 16-bit variants (saturating and wrapping).
module tb_pe_vec_mac;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        outReady;
  logic [31:0] act;
  logic [31:0] wgt;
  logic [31:0] inPsum;
  logic        beatMode;
  logic        beatFirst;
  logic        beatLast;

  logic        inReady0, outValid0, ovf0;
  logic [31:0] outPsum0;
  logic        inReadyS, outValidS, ovfS;
  logic [31:0] outPsumS;
  logic        inReadyT, outValidT, ovfT;
  logic [15:0] outPsumT;
  logic        inReadyW, outValidW, ovfW;
  logic [15:0] outPsumW;

  int vectorsApplied = 0;
  int miscompares    = 0;
  int got            = 0;
  logic [31:0] expQ[$];

  pe_vec_mac dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady0),
    .activation(act), .weight(wgt), .in_psum(inPsum), .mode(beatMode),
    .first(beatFirst), .last(beatLast), .out_valid(outValid0),
    .out_ready(outReady), .out_psum(outPsum0), .overflow(ovf0)
  );

  pe_vec_mac #(.SeM(1)) dutSem (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyS),
    .activation(act), .weight(wgt), .in_psum(inPsum), .mode(beatMode),
    .first(beatFirst), .last(beatLast), .out_valid(outValidS),
    .out_ready(outReady), .out_psum(outPsumS), .overflow(ovfS)
  );

  pe_vec_mac #(.accumulationPar(16), .LANES(1), .SATURATE(1)) dutSat (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyT),
    .activation(act[7:0]), .weight(wgt[7:0]), .in_psum(inPsum[15:0]),
    .mode(beatMode), .first(beatFirst), .last(beatLast),
    .out_valid(outValidT), .out_ready(outReady), .out_psum(outPsumT),
    .overflow(ovfT)
  );

  pe_vec_mac #(.accumulationPar(16), .LANES(1), .SATURATE(0)) dutWrap (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyW),
    .activation(act[7:0]), .weight(wgt[7:0]), .in_psum(inPsum[15:0]),
    .mode(beatMode), .first(beatFirst), .last(beatLast),
    .out_valid(outValidW), .out_ready(outReady), .out_psum(outPsumW),
    .overflow(ovfW)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    vectorsApplied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setBeat(input logic m, input logic f, input logic l,
                         input logic [31:0] psum, input logic [31:0] a,
                         input logic [31:0] w);
    inValid   = 1'b1;
    beatMode  = m;
    beatFirst = f;
    beatLast  = l;
    inPsum    = psum;
    act       = a;
    wgt       = w;
  endtask

  task automatic idle();
    inValid   = 1'b0;
    beatFirst = 1'b0;
    beatLast  = 1'b0;
  endtask

  initial begin
    inValid = 1'b0; outReady = 1'b1; act = '0; wgt = '0; inPsum = '0;
    beatMode = 1'b0; beatFirst = 1'b0; beatLast = 1'b0; rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checkVal("reset out_valid", 32'(outValid0), 32'd0);
    checkVal("reset out_psum", outPsum0, 32'd0);
    checkVal("reset overflow", 32'(ovf0), 32'd0);
    checkVal("reset in_ready", 32'(inReady0), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Chain mode: {1,2,3,4}.{5,-6,7,-8} = -18, +100 = 82
    setBeat(1'b0, 1'b0, 1'b0, 32'd100, 32'h04030201, 32'hF807FA05);
    tick(); idle(); tick();
    checkVal("m0 valid", 32'(outValid0), 32'd1);
    checkVal("m0 psum", outPsum0, 32'd82);
    checkVal("m0 ovf", 32'(ovf0), 32'd0);
    tick();
    checkVal("m0 valid drop", 32'(outValid0), 32'd0);

    // Back-to-back chain beats: 0+2*3 = 6, then 10-18 = -8
    setBeat(1'b0, 1'b0, 1'b0, 32'd0, 32'd2, 32'd3);
    tick();
    setBeat(1'b0, 1'b0, 1'b0, 32'd10, 32'h04030201, 32'hF807FA05);
    tick();
    checkVal("b2b first valid", 32'(outValid0), 32'd1);
    checkVal("b2b first psum", outPsum0, 32'd6);
    idle(); tick();
    checkVal("b2b second valid", 32'(outValid0), 32'd1);
    checkVal("b2b second psum", outPsum0, 32'hFFFFFFF8);
    tick();

    // Accumulate group: 1000 + 10 + 20 - 5 = 1025, then single-beat group 7
    setBeat(1'b1, 1'b1, 1'b0, 32'd1000, 32'd10, 32'd1);
    tick();
    setBeat(1'b1, 1'b0, 1'b0, 32'd555, 32'd20, 32'd1);
    tick();
    checkVal("grp beat1 no out", 32'(outValid0), 32'd0);
    setBeat(1'b1, 1'b0, 1'b1, 32'd555, 32'h000000FB, 32'd1);
    tick();
    checkVal("grp beat2 no out", 32'(outValid0), 32'd0);
    setBeat(1'b1, 1'b1, 1'b1, 32'd0, 32'd7, 32'd1);
    tick();
    checkVal("grp last valid", 32'(outValid0), 32'd1);
    checkVal("grp last psum", outPsum0, 32'd1025);
    idle(); tick();
    checkVal("single grp psum", outPsum0, 32'd7);
    tick();

    // Chain beat inside an open group: 82 out, group closes at 1030
    setBeat(1'b1, 1'b1, 1'b0, 32'd1000, 32'd10, 32'd1);
    tick();
    setBeat(1'b0, 1'b0, 1'b0, 32'd100, 32'h04030201, 32'hF807FA05);
    tick();
    setBeat(1'b1, 1'b0, 1'b1, 32'd555, 32'd20, 32'd1);
    tick();
    checkVal("interleave chain", outPsum0, 32'd82);
    idle(); tick();
    checkVal("interleave group", outPsum0, 32'd1030);
    tick();

    // Sign-magnitude: 0x85*0x03 = -15; -0 lane gives 0, (-2)*(-4) = 8, +5 = 13
    setBeat(1'b0, 1'b0, 1'b0, 32'd0, 32'h00000085, 32'h00000003);
    tick();
    setBeat(1'b0, 1'b0, 1'b0, 32'd5, 32'h00008280, 32'h00008483);
    tick();
    checkVal("sem neg product", outPsumS, 32'hFFFFFFF1);
    checkVal("sem ovf", 32'(ovfS), 32'd0);
    checkVal("twos same operands", outPsum0, 32'hFFFFFE8F);
    idle(); tick();
    checkVal("sem minus zero", outPsumS, 32'd13);
    tick();

    // Saturate vs wrap at 16 bits: 32760+100 and -32760-100
    setBeat(1'b0, 1'b0, 1'b0, 32'd32760, 32'd10, 32'd10);
    tick();
    setBeat(1'b0, 1'b0, 1'b0, 32'hFFFF8008, 32'h000000F6, 32'd10);
    tick();
    checkVal("sat pos psum", 32'(outPsumT), 32'h00007FFF);
    checkVal("sat pos ovf", 32'(ovfT), 32'd1);
    checkVal("wrap pos psum", 32'(outPsumW), 32'h0000805C);
    checkVal("wrap pos ovf", 32'(ovfW), 32'd1);
    idle(); tick();
    checkVal("sat neg psum", 32'(outPsumT), 32'h00008000);
    checkVal("sat neg ovf", 32'(ovfT), 32'd1);
    checkVal("wrap neg psum", 32'(outPsumW), 32'h00007FA4);
    tick();

    // Sticky overflow across a group, then a clean chain beat
    setBeat(1'b1, 1'b1, 1'b0, 32'd32760, 32'd10, 32'd10);
    tick();
    setBeat(1'b1, 1'b0, 1'b1, 32'd0, 32'h000000F6, 32'd10);
    tick();
    setBeat(1'b0, 1'b0, 1'b0, 32'd1, 32'd0, 32'd0);
    tick();
    checkVal("sticky sat psum", 32'(outPsumT), 32'h00007F9B);
    checkVal("sticky sat ovf", 32'(ovfT), 32'd1);
    checkVal("sticky wrap psum", 32'(outPsumW), 32'h00007FF8);
    checkVal("sticky wrap ovf", 32'(ovfW), 32'd1);
    idle(); tick();
    checkVal("clean chain psum", 32'(outPsumT), 32'd1);
    checkVal("clean chain ovf", 32'(ovfT), 32'd0);
    tick();

    // Back-pressure: 8 streamed beats, out_ready low for 5 cycles
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic accepted;
          accepted = 1'b0;
          setBeat(1'b0, 1'b0, 1'b0, 32'(i * 1000), 32'(i + 1), 32'd3);
          expQ.push_back(32'(i * 1000 + 3 * (i + 1)));
          for (int c = 0; c < 20 && !accepted; c++) begin
            @(negedge clk);
            if (inReady0) accepted = 1'b1;
            @(posedge clk);
            #1;
          end
          if (!accepted) checkVal("bp accept timeout", 32'd0, 32'd1);
        end
        idle();
      end
      begin
        repeat (3) tick();
        outReady = 1'b0;
        repeat (5) tick();
        outReady = 1'b1;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (outValid0) begin
            if (expQ.size() == 0) begin
              checkVal("bp extra result", 32'd1, 32'd0);
            end else if (outReady) begin
              checkVal("bp data", outPsum0, expQ.pop_front());
              got++;
            end else begin
              checkVal("bp in_ready", 32'(inReady0), 32'd0);
              checkVal("bp hold", outPsum0, expQ[0]);
            end
          end
        end
      end
    join
    checkVal("bp count", 32'(got), 32'd8);

    // Reset mid-stream while stalled with an open group
    setBeat(1'b1, 1'b1, 1'b0, 32'd500, 32'd1, 32'd1);
    tick();
    outReady = 1'b0;
    setBeat(1'b0, 1'b0, 1'b0, 32'd5, 32'd0, 32'd0);
    tick(); idle(); tick();
    checkVal("pre-reset stalled", 32'(outValid0 & ~inReady0), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkVal("mid reset out_valid", 32'(outValid0), 32'd0);
    checkVal("mid reset out_psum", outPsum0, 32'd0);
    checkVal("mid reset overflow", 32'(ovf0), 32'd0);
    checkVal("mid reset in_ready", 32'(inReady0), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    outReady = 1'b1;
    setBeat(1'b1, 1'b0, 1'b1, 32'd999, 32'd7, 32'd1);
    tick(); idle(); tick();
    checkVal("acc cleared by reset", outPsum0, 32'd7);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_vec_mac.md
Name: pe_vec_mac

Overview:
- Next-generation processing element for the systolic MAC array.
- Computes a LANES-wide dot product of activation and weight vectors per beat.
- Two modes: pass-through partial-sum chaining (mode 0) or local output-stationary accumulation over a group of beats (mode 1).
- Adds a valid/ready handshake with back-pressure, selectable sign-magnitude or two's-complement operands, and saturating or wrapping accumulation with an overflow flag.

Parameters:
- weightPar, 8, bit width of each activation/weight element (sign bit included).
- accumulationPar, 32, width of partial sums and accumulator; elaboration error if < 2*weightPar + clog2(LANES).
- LANES, 4, multipliers per PE (dot-product length per beat); >= 1.
- SeM, 0, 1 = operands are sign-magnitude; 0 = two's complement.
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^accumulationPar.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  PE can accept a beat.
- activation  in  LANES*weightPar  element i at bits [i*weightPar +: weightPar].
- weight  in  LANES*weightPar  same packing as activation.
- in_psum  in  accumulationPar  incoming two's-complement partial sum.
- mode  in  1  0 = chain, 1 = accumulate; sampled per beat.
- first  in  1  mode 1: seeds the accumulator from in_psum.
- last  in  1  mode 1: emits the accumulator.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_psum  out  accumulationPar  two's-complement result.
- overflow  out  1  sideband, qualified by out_valid.

Behaviour:
- Reset: all outputs and internal state go to 0 immediately. This covers out_valid, out_psum, overflow, the accumulator, the sticky flag and the stage-1 valid. In-flight beats are discarded. in_ready = 1 once rst deasserts.
- Pipeline:
  - Stage 1 registers operands, in_psum, mode, first and last.
  - Stage 2 computes the products and adder tree, then updates the accumulator/output register.
  - A beat accepted on edge E gives out_valid from edge E+1 (mode 0, or mode 1 with last).
- Handshake:
  - A beat is accepted when in_valid && in_ready. Output is consumed when out_valid && out_ready.
  - stall = out_valid && !out_ready. in_ready = !stall. Stage 1 and the output hold while stalled.
  - Full throughput of 1 beat/cycle with out_ready held high.
  - out_psum and overflow stay stable while out_valid && !out_ready.
- Products, SeM = 1:
  - magnitude = low weightPar-1 bits; sign = XOR of the operand MSBs.
  - Products are converted to two's complement and sign-extended to accumulationPar+1 bits.
  - A zero magnitude (including -0) yields exactly 0.
- Products, SeM = 0: signed multiply, sign-extended.
- dot = exact sum of LANES products (no intermediate truncation).
- Mode 0 (chain): out_psum = fix(in_psum + dot). The accumulator is untouched; first and last are ignored.
- Mode 1 (accumulate):
  - next = (first ? in_psum : acc) + dot, then acc <= fix(next).
  - When last: out_psum <= fix(next), out_valid <= 1, and acc <= 0.
  - first && last on the same beat gives a single-beat group.
  - Beats without last produce no output.
- Interleaving: mode-0 beats inside an open mode-1 group leave acc and the sticky flag untouched.
- fix(x):
  - Computed at accumulationPar+1 bits.
  - Overflow when x is outside [-2^(accumulationPar-1), 2^(accumulationPar-1)-1].
  - SATURATE = 1 clamps to the bound; SATURATE = 0 truncates.
- Overflow flag:
  - Mode 0: reports that beat's overflow.
  - Mode 1: sticky across the group; cleared on first, reported on last.
- Mode 1 beat with neither first seen nor reset: accumulates onto the current acc, which is 0 after reset or after a last.

Test Plan:
- Reset mid-stream: assert rst while out_valid = 1 and stall = 1 -> out_valid = 0, out_psum = 0, overflow = 0, in_ready = 1 in the same cycle; acc is 0 afterwards.
- Mode 0, SeM = 0, LANES = 4: activation {1,2,3,4}, weight {5,-6,7,-8}, in_psum = 100 -> dot = -18, out_psum = 82, overflow = 0 at E+1. Back-to-back beats with out_ready = 1 give one result per cycle.
- Mode 1 group of 3 beats, dot = 10, 20, -5, first.in_psum = 1000 -> no out_valid on beats 1–2; out_psum = 1025 after the last. A following single beat with first && last, in_psum = 0, dot = 7 -> out_psum = 7.
- SeM = 1, weightPar = 8: activation 0x85 (-5), weight 0x03 (+3) in lane 0, all other lanes 0 -> out_psum = -15. activation 0x80 (-0) with weight 0x83 -> product 0.
- Saturation, accumulationPar = 16: mode 0, in_psum = 32760, dot = 100 -> out_psum = 32767, overflow = 1. With SATURATE = 0 -> out_psum = -32676, overflow = 1.
- Back-pressure: hold out_ready = 0 for 5 cycles while streaming -> in_ready = 0 during the stall. out_psum is held, no beat is lost or duplicated, and the results after release match the scoreboard in order.
